// File: rtl/fanin_8to1_arb.sv
// Eight-way round-robin fan-in: grants one requester per cycle into a single
// output register tagged with the winning source index.
module fanin_8to1_arb #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     in_valid,
  input  logic [8*W-1:0] in_data,
  output logic [7:0]     in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [2:0]     out_src,
  input  logic           out_ready
);

  // Handshake: a word moves on any edge where valid and ready are both high on
  // the same side; in_ready is at most one-hot and out_valid never waits on
  // out_ready.
  logic [2:0] ptr;
  logic       cap_en;
  logic       found;
  logic [2:0] winner;
  logic [2:0] idx;

  always_comb begin
    cap_en = !out_valid || out_ready;
    found  = 1'b0;
    winner = ptr;
    idx    = ptr;
    // Scan starts at ptr; 3-bit addition supplies the 7->0 wrap.
    for (int k = 0; k < 8; k++) begin
      idx = ptr + 3'(k);
      if (!found && in_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    in_ready = '0;
    if (cap_en && found && !rst) in_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (cap_en) begin
      if (found) begin
        out_valid <= 1'b1;
        out_data  <= in_data[winner*W +: W];
        out_src   <= winner;
        ptr       <= winner + 3'd1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
